// File: rtl/bcd_conv_arbiter_if.sv
// Bundle of requester-side and converter-side signals around bcd_conv_arbiter.
// slave modport: the arbiter. master modport: the surrounding clients and converter.
interface bcd_conv_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int N       = 13
);
    // requester side
    logic [NUM_REQ-1:0]   req_i;
    logic [NUM_REQ*N-1:0] bcd_i;
    logic [NUM_REQ-1:0]   gnt_o;
    logic [NUM_REQ-1:0]   done_o;
    logic [31:0]          binary_o;
    logic                 err_o;
    logic                 busy_o;
    // converter side
    logic                 conv_start_o;
    logic [N-1:0]         conv_bcd_o;
    logic                 conv_ready_i;
    logic                 conv_done_i;
    logic [31:0]          conv_binary_i;

    modport slave (
        input  req_i, bcd_i, conv_ready_i, conv_done_i, conv_binary_i,
        output gnt_o, done_o, binary_o, err_o, busy_o, conv_start_o, conv_bcd_o
    );

    modport master (
        output req_i, bcd_i, conv_ready_i, conv_done_i, conv_binary_i,
        input  gnt_o, done_o, binary_o, err_o, busy_o, conv_start_o, conv_bcd_o
    );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one sequential BCD-to-binary converter among
// NUM_REQ requesters. One request in flight at a time: IDLE -> LAUNCH -> WAIT -> RESP.
// Every output is a flop, so all outputs are Moore-style.
// Optional feature macro: BCD_ARB_CHECK_EN -- when defined, operands containing a
// complete digit above 9 are rejected (granted, never started, answered with err_o=1).
module bcd_conv_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int N       = 13
) (
    input  logic              clk_i,
    input  logic              reset_i,
    bcd_conv_arbiter_if.slave bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int ND = N / 4;  // complete digits only; a partial top digit is never checked
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t               state_reg, state_next;
    logic [PW-1:0]        ptr_reg, ptr_next;
    logic [PW-1:0]        owner_reg, owner_next;
    logic [N-1:0]         operand_reg, operand_next;
    logic                 bad_reg, bad_next;
    logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
    logic [NUM_REQ-1:0]   done_reg, done_next;
    logic [31:0]          binary_reg, binary_next;
    logic                 err_reg, err_next;
    logic                 busy_reg, busy_next;
    logic                 start_reg, start_next;

    logic [N-1:0]         operand_arr [NUM_REQ];
    logic                 found;
    logic [PW-1:0]        win;
    logic [PW-1:0]        cand;
    int                   idx;
    logic [N-1:0]         win_operand;
    logic                 win_bad;
    logic [PW-1:0]        ptr_inc;

    genvar gi;

    // Slice the flat operand bus into one entry per requester.
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign operand_arr[gi] = bus.bcd_i[gi*N +: N];
        end
    endgenerate

    // Round-robin search: first active request at or above the pointer, with wrap.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_reg) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = PW'(idx);
            if (!found && bus.req_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign win_operand = operand_arr[win];

`ifdef BCD_ARB_CHECK_EN
    logic [ND-1:0] digit_bad;
    generate
        for (gi = 0; gi < ND; gi++) begin : g_digit
            assign digit_bad[gi] = (win_operand[gi*4 +: 4] > 4'd9);
        end
    endgenerate
    assign win_bad = |digit_bad;
`else
    assign win_bad = 1'b0;
`endif

    // Just-served requester becomes lowest priority.
    assign ptr_inc = (int'(owner_reg) == NUM_REQ - 1) ? '0 : owner_reg + PW'(1);

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        owner_next   = owner_reg;
        operand_next = operand_reg;
        bad_next     = bad_reg;
        binary_next  = binary_reg;
        err_next     = err_reg;
        gnt_next     = '0;
        done_next    = '0;
        start_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (found && bus.conv_ready_i) begin
                    state_next   = LAUNCH;
                    owner_next   = win;
                    operand_next = win_operand;
                    bad_next     = win_bad;
                    gnt_next     = ONE << win;
                    start_next   = !win_bad;
                end
            end
            LAUNCH: begin
                ptr_next = ptr_inc;
                if (bad_reg) begin
                    // rejected operand: skip the converter and answer immediately
                    state_next  = RESP;
                    binary_next = '0;
                    err_next    = 1'b1;
                    done_next   = ONE << owner_reg;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.conv_done_i) begin
                    state_next  = RESP;
                    binary_next = bus.conv_binary_i;
                    err_next    = 1'b0;
                    done_next   = ONE << owner_reg;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            owner_reg   <= '0;
            operand_reg <= '0;
            bad_reg     <= 1'b0;
            gnt_reg     <= '0;
            done_reg    <= '0;
            binary_reg  <= '0;
            err_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            start_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            owner_reg   <= owner_next;
            operand_reg <= operand_next;
            bad_reg     <= bad_next;
            gnt_reg     <= gnt_next;
            done_reg    <= done_next;
            binary_reg  <= binary_next;
            err_reg     <= err_next;
            busy_reg    <= busy_next;
            start_reg   <= start_next;
        end
    end

    assign bus.gnt_o        = gnt_reg;
    assign bus.done_o       = done_reg;
    assign bus.binary_o     = binary_reg;
    assign bus.err_o        = err_reg;
    assign bus.busy_o       = busy_reg;
    assign bus.conv_start_o = start_reg;
    assign bus.conv_bcd_o   = operand_reg;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter paired with a behavioural converter
// (32 busy cycles after start, then a one-cycle done pulse).
// Define BCD_ARB_CHECK_EN to exercise the invalid-digit path.
`timescale 1ns/1ps
module tb_bcd_conv_arbiter;
    logic clk_i;
    logic reset_i;
    int   total;
    int   bad;

    bcd_conv_arbiter_if #(.NUM_REQ(4), .N(13)) bus();

    bcd_conv_arbiter #(.NUM_REQ(4), .N(13)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Converter model
    logic        m_busy, m_done, m_ready;
    logic [5:0]  m_cnt;
    logic [12:0] m_opnd;
    logic [31:0] m_bin;
    logic        ready_en;
    logic        inject_done;

    function automatic logic [31:0] bcd2bin(input logic [12:0] v);
        return 32'(v[3:0]) + 32'(v[7:4]) * 10 + 32'(v[11:8]) * 100 + 32'(v[12]) * 1000;
    endfunction

    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_ready <= 1'b1;
            m_cnt <= '0; m_opnd <= '0; m_bin <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 6'd31) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_bin  <= bcd2bin(m_opnd);
                end else begin
                    m_cnt <= m_cnt + 6'd1;
                end
            end else if (m_done) begin
                m_ready <= 1'b1;
            end else if (bus.conv_start_o && m_ready) begin
                m_busy  <= 1'b1;
                m_cnt   <= '0;
                m_ready <= 1'b0;
                m_opnd  <= bus.conv_bcd_o;
            end
        end
    end

    assign bus.conv_ready_i  = m_ready & ready_en;
    assign bus.conv_done_i   = m_done | inject_done;
    assign bus.conv_binary_i = m_bin;

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        bus.req_i = '0;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    task automatic wait_gnt(input int limit, output int cyc, output logic [3:0] g);
        logic hit;
        hit = 1'b0; cyc = 0; g = '0;
        while (!hit && cyc < limit) begin
            @(negedge clk_i);
            cyc++;
            if (bus.gnt_o != 0) begin hit = 1'b1; g = bus.gnt_o; end
        end
        if (!hit) cyc = -1;
    endtask

    task automatic wait_done(input int limit, output int cyc, output logic [3:0] d, output logic saw_start);
        logic hit;
        hit = 1'b0; cyc = 0; d = '0; saw_start = 1'b0;
        while (!hit && cyc < limit) begin
            @(negedge clk_i);
            cyc++;
            if (bus.conv_start_o) saw_start = 1'b1;
            if (bus.done_o != 0) begin hit = 1'b1; d = bus.done_o; end
        end
        if (!hit) cyc = -1;
    endtask

    task automatic test_reset();
        int stray;
        reset_i = 1'b1; bus.req_i = '0; bus.bcd_i = '0;
        ready_en = 1'b1; inject_done = 1'b0;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        total++;
        if ({bus.gnt_o, bus.done_o, bus.busy_o, bus.conv_start_o, bus.err_o, bus.binary_o, bus.conv_bcd_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: gnt=%b done=%b busy=%b start=%b err=%b bin=%0d bcd=%h, want all 0",
                     bus.gnt_o, bus.done_o, bus.busy_o, bus.conv_start_o, bus.err_o, bus.binary_o, bus.conv_bcd_o);
        end
        // stray converter done in IDLE must be ignored
        inject_done = 1'b1;
        @(negedge clk_i);
        inject_done = 1'b0;
        stray = 0;
        repeat (3) begin
            @(negedge clk_i);
            if (bus.done_o != 0 || bus.busy_o) stray++;
        end
        total++;
        if (stray !== 0) begin
            bad++;
            $display("FAIL idle_done_ignored: %0d cycles with done/busy, want 0", stray);
        end
        $display("reset test complete");
    endtask

    task automatic test_single();
        int cyc; logic [3:0] g, d; logic ss;
        do_reset();
        bus.bcd_i = '0;
        bus.bcd_i[12:0] = 13'h0999;
        bus.req_i = 4'b0001;
        wait_gnt(10, cyc, g);
        total++;
        if (cyc !== 1 || g !== 4'b0001) begin
            bad++; $display("FAIL single_gnt: cyc=%0d gnt=%b, want cyc=1 gnt=0001", cyc, g);
        end
        total++;
        if (bus.conv_start_o !== 1'b1 || bus.conv_bcd_o !== 13'h0999 || bus.busy_o !== 1'b1) begin
            bad++; $display("FAIL single_launch: start=%b bcd=%h busy=%b, want 1 0999 1",
                            bus.conv_start_o, bus.conv_bcd_o, bus.busy_o);
        end
        bus.req_i = '0;
        wait_done(60, cyc, d, ss);
        total++;
        if (cyc !== 34 || d !== 4'b0001) begin
            bad++; $display("FAIL single_done: cyc=%0d done=%b, want cyc=34 done=0001", cyc, d);
        end
        total++;
        if (bus.binary_o !== 32'd999 || bus.err_o !== 1'b0) begin
            bad++; $display("FAIL single_result: bin=%0d err=%b, want 999 0", bus.binary_o, bus.err_o);
        end
        @(negedge clk_i);
        total++;
        if (bus.done_o !== 4'b0000 || bus.busy_o !== 1'b0 || bus.binary_o !== 32'd999) begin
            bad++; $display("FAIL single_after: done=%b busy=%b bin=%0d, want 0000 0 999",
                            bus.done_o, bus.busy_o, bus.binary_o);
        end
        $display("single request: gnt and done checked, binary=%0d", bus.binary_o);
    endtask

    task automatic test_round_robin();
        int cyc; logic [3:0] g, d; logic ss;
        logic [12:0] ops [4];
        int exps [4];
        ops[0] = 13'h0123; ops[1] = 13'h0456; ops[2] = 13'h0789; ops[3] = 13'h1024;
        exps[0] = 123; exps[1] = 456; exps[2] = 789; exps[3] = 1024;
        do_reset();
        for (int k = 0; k < 4; k++) bus.bcd_i[k*13 +: 13] = ops[k];
        bus.req_i = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(10, cyc, g);
            total++;
            if (g !== 4'(1 << k) || (k > 0 && cyc !== 2)) begin
                bad++; $display("FAIL rr_gnt%0d: gnt=%b cyc=%0d, want gnt=%b cyc=2", k, g, cyc, 4'(1 << k));
            end
            bus.req_i[k] = 1'b0;
            wait_done(60, cyc, d, ss);
            total++;
            if (d !== 4'(1 << k) || bus.binary_o !== 32'(exps[k])) begin
                bad++; $display("FAIL rr_done%0d: done=%b bin=%0d, want %b %0d", k, d, bus.binary_o, 4'(1 << k), exps[k]);
            end
            $display("round robin: requester %0d served, binary=%0d", k, bus.binary_o);
        end
    endtask

    task automatic test_back_to_back();
        int cyc; int w; logic [3:0] g, d; logic ss;
        do_reset();
        bus.bcd_i = '0;
        bus.bcd_i[0*13 +: 13] = 13'h0011;
        bus.bcd_i[2*13 +: 13] = 13'h0022;
        bus.req_i = 4'b0101;
        for (int n = 0; n < 6; n++) begin
            w = (n % 2 == 0) ? 0 : 2;
            wait_gnt(10, cyc, g);
            total++;
            if (g !== 4'(1 << w)) begin
                bad++; $display("FAIL alt_gnt%0d: gnt=%b, want %b", n, g, 4'(1 << w));
            end
            bus.req_i[w] = 1'b0;
            wait_done(60, cyc, d, ss);
            total++;
            if (d !== 4'(1 << w) || bus.binary_o !== ((w == 0) ? 32'd11 : 32'd22)) begin
                bad++; $display("FAIL alt_done%0d: done=%b bin=%0d, want %b %0d",
                                n, d, bus.binary_o, 4'(1 << w), (w == 0) ? 11 : 22);
            end
            bus.req_i[w] = 1'b1;
            $display("back to back: grant %0d to requester %0d", n, w);
        end
        bus.req_i = '0;
    endtask

    task automatic test_ready_gate();
        int cyc; int stray; logic [3:0] d; logic ss;
        do_reset();
        ready_en = 1'b0;
        bus.bcd_i = '0;
        bus.bcd_i[1*13 +: 13] = 13'h0042;
        bus.req_i = 4'b0010;
        stray = 0;
        repeat (10) begin
            @(negedge clk_i);
            if (bus.gnt_o != 0) stray++;
        end
        total++;
        if (stray !== 0) begin
            bad++; $display("FAIL ready_block: %0d grants while not ready, want 0", stray);
        end
        ready_en = 1'b1;
        @(negedge clk_i);
        total++;
        if (bus.gnt_o !== 4'b0010) begin
            bad++; $display("FAIL ready_gnt: gnt=%b, want 0010", bus.gnt_o);
        end
        bus.req_i = '0;
        wait_done(60, cyc, d, ss);
        total++;
        if (d !== 4'b0010 || bus.binary_o !== 32'd42) begin
            bad++; $display("FAIL ready_done: done=%b bin=%0d, want 0010 42", d, bus.binary_o);
        end
        $display("ready gate: binary=%0d", bus.binary_o);
    endtask

    task automatic test_reset_mid();
        int cyc; int stray; logic [3:0] g, d; logic ss;
        bus.bcd_i = '0;
        bus.bcd_i[12:0] = 13'h0555;
        bus.req_i = 4'b0001;
        wait_gnt(10, cyc, g);
        total++;
        if (g !== 4'b0001) begin
            bad++; $display("FAIL mid_gnt: gnt=%b, want 0001", g);
        end
        bus.req_i = '0;
        repeat (5) @(negedge clk_i);
        total++;
        if (bus.busy_o !== 1'b1) begin
            bad++; $display("FAIL mid_busy: busy=%b, want 1", bus.busy_o);
        end
        reset_i = 1'b1;
        @(negedge clk_i);
        total++;
        if ({bus.gnt_o, bus.done_o, bus.busy_o, bus.conv_start_o, bus.err_o, bus.binary_o, bus.conv_bcd_o} !== '0) begin
            bad++; $display("FAIL mid_reset: gnt=%b done=%b busy=%b start=%b bin=%0d bcd=%h, want all 0",
                            bus.gnt_o, bus.done_o, bus.busy_o, bus.conv_start_o, bus.binary_o, bus.conv_bcd_o);
        end
        reset_i = 1'b0;
        stray = 0;
        repeat (45) begin
            @(negedge clk_i);
            if (bus.done_o != 0) stray++;
        end
        total++;
        if (stray !== 0) begin
            bad++; $display("FAIL mid_no_done: %0d done pulses after abort, want 0", stray);
        end
        // pointer back at 0: requester 0 wins over requester 1
        bus.bcd_i[0*13 +: 13] = 13'h0001;
        bus.bcd_i[1*13 +: 13] = 13'h0002;
        bus.req_i = 4'b0011;
        wait_gnt(10, cyc, g);
        total++;
        if (g !== 4'b0001) begin
            bad++; $display("FAIL mid_ptr: gnt=%b, want 0001", g);
        end
        bus.req_i = '0;
        wait_done(60, cyc, d, ss);
        bus.bcd_i[3*13 +: 13] = 13'h1234;
        bus.req_i = 4'b1000;
        wait_gnt(10, cyc, g);
        bus.req_i = '0;
        wait_done(60, cyc, d, ss);
        total++;
        if (g !== 4'b1000 || d !== 4'b1000 || bus.binary_o !== 32'd1234) begin
            bad++; $display("FAIL mid_after: gnt=%b done=%b bin=%0d, want 1000 1000 1234", g, d, bus.binary_o);
        end
        $display("reset mid-operation: recovered, binary=%0d", bus.binary_o);
    endtask

    task automatic test_invalid();
        int cyc; logic [3:0] g, d; logic ss, st;
        do_reset();
        bus.bcd_i = '0;
        bus.bcd_i[12:0] = 13'h00A5;
        bus.req_i = 4'b0001;
        wait_gnt(10, cyc, g);
        st = bus.conv_start_o;
        bus.req_i = '0;
        total++;
        if (g !== 4'b0001) begin
            bad++; $display("FAIL inv_gnt: gnt=%b, want 0001", g);
        end
        wait_done(60, cyc, d, ss);
`ifdef BCD_ARB_CHECK_EN
        total++;
        if (cyc !== 1 || d !== 4'b0001 || bus.err_o !== 1'b1 || bus.binary_o !== 32'd0 || (st | ss) !== 1'b0) begin
            bad++; $display("FAIL inv_reject: cyc=%0d done=%b err=%b bin=%0d start=%b, want 1 0001 1 0 0",
                            cyc, d, bus.err_o, bus.binary_o, st | ss);
        end
`else
        total++;
        if (cyc !== 34 || d !== 4'b0001 || bus.err_o !== 1'b0 || bus.binary_o !== 32'd105 || st !== 1'b1) begin
            bad++; $display("FAIL inv_pass: cyc=%0d done=%b err=%b bin=%0d start=%b, want 34 0001 0 105 1",
                            cyc, d, bus.err_o, bus.binary_o, st);
        end
`endif
        // a valid operand afterwards clears err_o
        bus.bcd_i[1*13 +: 13] = 13'h0321;
        bus.req_i = 4'b0010;
        wait_gnt(10, cyc, g);
        bus.req_i = '0;
        wait_done(60, cyc, d, ss);
        total++;
        if (d !== 4'b0010 || bus.err_o !== 1'b0 || bus.binary_o !== 32'd321) begin
            bad++; $display("FAIL inv_follow: done=%b err=%b bin=%0d, want 0010 0 321", d, bus.err_o, bus.binary_o);
        end
        $display("invalid digit: err=%b binary=%0d after follow-up", bus.err_o, bus.binary_o);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        ready_en = 1'b1;
        inject_done = 1'b0;
        reset_i = 1'b1;
        bus.req_i = '0;
        bus.bcd_i = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_ready_gate();
        test_reset_mid();
        test_invalid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
